// File: rtl/fb_box_painter.sv
// Purpose: owns the frame-buffer write port; clears it, draws an 8x8 box, and moves the box once per frame on vs.
// Latency: the first write follows reset release by one clock; a move starts writing 2 clocks after the vs edge and ends 130 clocks after it.
// Backpressure: none; one pixel is written per cycle while we=1, and vs edges that arrive while busy are dropped.
module fb_box_painter #(
   parameter int          H_LEN    = 200,
   parameter int          V_LEN    = 150,
   parameter int          BOX      = 8,
   parameter int          STEP     = 2,
   parameter logic [11:0] BG_COLOR = 12'h000,
   parameter logic [11:0] FG_COLOR = 12'hF00
) (
   input  logic        clk_px,
   input  logic        rstn,
   input  logic        vs,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   output logic [14:0] waddr,
   output logic [11:0] wdata,
   output logic        we,
   output logic        busy,
   output logic [7:0]  pos_x,
   output logic [7:0]  pos_y
);

   localparam int          NPIX      = H_LEN * V_LEN;
   localparam int          BW        = (BOX > 1) ? $clog2(BOX) : 1;
   localparam logic [7:0]  X0        = 8'((H_LEN - BOX) / 2);
   localparam logic [7:0]  Y0        = 8'((V_LEN - BOX) / 2);
   localparam logic [7:0]  X_MAX     = 8'(H_LEN - BOX);
   localparam logic [7:0]  Y_MAX     = 8'(V_LEN - BOX);
   localparam logic [7:0]  STEP8     = 8'(STEP);
   localparam logic [14:0] ORG0      = 15'(((V_LEN - BOX) / 2) * H_LEN + (H_LEN - BOX) / 2);
   localparam logic [14:0] H_ADD     = 15'(H_LEN);
   localparam logic [14:0] LAST_ADDR = 15'(NPIX - 1);
   localparam logic [BW-1:0] BOX_LAST = BW'(BOX - 1);

   typedef enum logic [2:0] {CLEAR, DRAW, IDLE, CALC, ERASE} state_t;

   state_t        state, state_nxt;
   logic          vs_q;
   logic [14:0]   clr_cnt;
   logic [14:0]   row_base;
   logic [BW-1:0] col, row;
   logic [14:0]   org, norg_q;       // address of the box's top-left pixel, current and pending
   logic [7:0]    nx_q, ny_q;
   logic [7:0]    nx, ny, dy;
   logic [8:0]    x_inc, y_inc;
   logic [14:0]   row_off, norg;
   logic          vs_rise, box_last, clr_last;

   assign vs_rise  = vs & ~vs_q;
   assign box_last = (row == BOX_LAST) && (col == BOX_LAST);
   assign clr_last = (clr_cnt == LAST_ADDR);
   assign x_inc    = {1'b0, pos_x} + 9'(STEP);
   assign y_inc    = {1'b0, pos_y} + 9'(STEP);

   // New position from the buttons: opposing presses cancel, moves clamp at the edges.
   always_comb begin
      nx = pos_x;
      ny = pos_y;
      if (btn_left && !btn_right)
         nx = (pos_x < STEP8) ? 8'd0 : pos_x - STEP8;
      else if (btn_right && !btn_left)
         nx = (x_inc > {1'b0, X_MAX}) ? X_MAX : x_inc[7:0];
      if (btn_up && !btn_down)
         ny = (pos_y < STEP8) ? 8'd0 : pos_y - STEP8;
      else if (btn_down && !btn_up)
         ny = (y_inc > {1'b0, Y_MAX}) ? Y_MAX : y_inc[7:0];
   end

   // New origin address by adding/subtracting whole rows; the row delta is at most STEP, so a short adder chain replaces a multiply.
   always_comb begin
      dy      = (ny > pos_y) ? ny - pos_y : pos_y - ny;
      row_off = '0;
      for (int i = 1; i <= STEP; i++)
         if (dy >= 8'(i))
            row_off = row_off + H_ADD;
      norg = org + 15'(nx) - 15'(pos_x);
      norg = (ny > pos_y) ? norg + row_off : norg - row_off;
   end

   // State register.
   always_ff @(posedge clk_px or negedge rstn) begin
      if (!rstn) state <= CLEAR;
      else       state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         CLEAR:   if (clr_last) state_nxt = DRAW;
         DRAW:    if (box_last) state_nxt = IDLE;
         IDLE:    if (vs_rise)  state_nxt = CALC;
         CALC:    state_nxt = ((nx == pos_x) && (ny == pos_y)) ? IDLE : ERASE;
         ERASE:   if (box_last) state_nxt = DRAW;
         default: state_nxt = CLEAR;
      endcase
   end

   // Registered write port, pixel walker and position bookkeeping.
   always_ff @(posedge clk_px or negedge rstn) begin
      if (!rstn) begin
         vs_q     <= 1'b0;
         waddr    <= '0;
         wdata    <= '0;
         we       <= 1'b0;
         busy     <= 1'b1;
         pos_x    <= X0;
         pos_y    <= Y0;
         nx_q     <= X0;
         ny_q     <= Y0;
         org      <= ORG0;
         norg_q   <= ORG0;
         clr_cnt  <= '0;
         row_base <= '0;
         col      <= '0;
         row      <= '0;
      end else begin
         vs_q <= vs;
         we   <= 1'b0;
         busy <= (state != IDLE) || vs_rise;
         case (state)
            CLEAR: begin
               we      <= 1'b1;
               waddr   <= clr_cnt;
               wdata   <= BG_COLOR;
               clr_cnt <= clr_cnt + 15'd1;
               if (clr_last) begin
                  row_base <= org;
                  col      <= '0;
                  row      <= '0;
               end
            end
            DRAW, ERASE: begin
               we    <= 1'b1;
               waddr <= row_base + 15'(col);
               wdata <= (state == DRAW) ? FG_COLOR : BG_COLOR;
               // The position becomes visible together with the first pixel of the new box.
               if (state == DRAW && row == '0 && col == '0) begin
                  pos_x <= nx_q;
                  pos_y <= ny_q;
                  org   <= norg_q;
               end
               if (col == BOX_LAST) begin
                  col      <= '0;
                  row      <= row + 1'b1;
                  row_base <= row_base + H_ADD;
               end else begin
                  col <= col + 1'b1;
               end
               if (box_last) begin
                  row <= '0;
                  if (state == ERASE) row_base <= norg_q;
               end
            end
            CALC: begin
               nx_q     <= nx;
               ny_q     <= ny;
               norg_q   <= norg;
               row_base <= org;
               col      <= '0;
               row      <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fb_box_painter.sv
// Purpose: checks every frame-buffer write of fb_box_painter against an address/colour queue built from the box rules.
// Latency: drives vs pulses and measures write start and busy fall in clocks after the detected edge.
// Backpressure: not applicable; the bench only observes the write port.
module tb_fb_box_painter;

   localparam int H = 200;
   localparam int V = 150;
   localparam int B = 8;
   localparam int S = 2;
   localparam int N = H * V;

   logic        clk_px = 1'b0;
   logic        rstn   = 1'b0;
   logic        vs     = 1'b0;
   logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
   logic [14:0] waddr;
   logic [11:0] wdata;
   logic        we, busy;
   logic [7:0]  pos_x, pos_y;

   int n_cmp  = 0;
   int n_fail = 0;
   int exp_a[$];
   int exp_d[$];
   logic [11:0] fb [N];
   int mx = 96, my = 71;

   fb_box_painter dut (
      .clk_px(clk_px), .rstn(rstn), .vs(vs),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .waddr(waddr), .wdata(wdata), .we(we), .busy(busy),
      .pos_x(pos_x), .pos_y(pos_y)
   );

   always #10 clk_px = ~clk_px;

   task automatic chk(input string nm, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, req);
      end
   endtask

   task automatic push_box(input int x, input int y, input int c);
      for (int r = 0; r < B; r++)
         for (int cc = 0; cc < B; cc++) begin
            exp_a.push_back((y + r) * H + x + cc);
            exp_d.push_back(c);
         end
   endtask

   task automatic push_clear();
      for (int i = 0; i < N; i++) begin
         exp_a.push_back(i);
         exp_d.push_back(0);
      end
   endtask

   function automatic int step_axis(input int p, input bit dec, input bit inc, input int maxv);
      if (dec && !inc) return (p < S) ? 0 : p - S;
      if (inc && !dec) return (p + S > maxv) ? maxv : p + S;
      return p;
   endfunction

   // Model of one frame's move: queue erase of the old box and draw of the new one if it moves.
   task automatic plan_move();
      int nx, ny;
      nx = step_axis(mx, btn_left, btn_right, H - B);
      ny = step_axis(my, btn_up, btn_down, V - B);
      if (nx != mx || ny != my) begin
         push_box(mx, my, 'h000);
         push_box(nx, ny, 'hF00);
         mx = nx;
         my = ny;
      end
   endtask

   // Every write is checked in order against the expected queue and mirrored into a frame-buffer image.
   always @(negedge clk_px) begin
      int a, d;
      if (rstn && we) begin
         if (exp_a.size() == 0) begin
            chk("unexpected_we", int'(waddr), -1);
         end else begin
            a = exp_a.pop_front();
            d = exp_d.pop_front();
            chk("waddr", int'(waddr), a);
            chk("wdata", int'(wdata), d);
         end
         if (int'(waddr) < N) fb[waddr] = wdata;
      end
   end

   // Release reset and run CLEAR+DRAW; optional vs pulses at clock k=pa and k=pb.
   task automatic release_clear(input int pa, input int pb, output int fall_k);
      fall_k = -1;
      @(negedge clk_px);
      rstn = 1'b1;
      for (int k = 1; k <= 40000; k++) begin
         @(posedge clk_px);
         #1;
         if (k == 1) begin
            chk("first_clear_we", int'(we), 1);
            chk("first_clear_addr", int'(waddr), 0);
         end
         vs = (k == pa || k == pb);
         if (!busy) begin
            fall_k = k;
            break;
         end
      end
      vs = 1'b0;
      if (fall_k < 0) chk("clear_timeout", 0, 1);
   endtask

   // One vs pulse; k counts clocks after the detected edge t. Optional extra vs pulse at k=mid_k.
   task automatic do_frame(input int mid_k, output int first_we_k, output int fall_k);
      first_we_k = -1;
      fall_k     = -1;
      @(negedge clk_px);
      vs = 1'b1;
      @(posedge clk_px);
      #1;
      chk("busy_at_edge", int'(busy), 1);
      @(negedge clk_px);
      vs = 1'b0;
      for (int k = 1; k <= 400; k++) begin
         @(posedge clk_px);
         #1;
         if (first_we_k < 0 && we) first_we_k = k;
         vs = (k == mid_k);
         if (!busy) begin
            fall_k = k;
            break;
         end
      end
      vs = 1'b0;
      if (fall_k < 0) chk("frame_timeout", 0, 1);
      chk("queue_drained", exp_a.size(), 0);
      chk("pos_x_model", int'(pos_x), mx);
      chk("pos_y_model", int'(pos_y), my);
   endtask

   initial begin
      int fw, bf, cnt;
      #25;
      chk("rst_we", int'(we), 0);
      chk("rst_waddr", int'(waddr), 0);
      chk("rst_wdata", int'(wdata), 0);
      chk("rst_busy", int'(busy), 1);
      chk("rst_pos_x", int'(pos_x), 96);
      chk("rst_pos_y", int'(pos_y), 71);

      push_clear();
      push_box(96, 71, 'hF00);
      chk("model_box_first", exp_a[N], 14296);
      chk("model_box_last", exp_a[N + 63], 15703);
      release_clear(-1, -1, bf);
      chk("clear_busy_fall", bf, 30065);
      chk("clear_drained", exp_a.size(), 0);
      chk("fb_box_px", int'(fb[14296]), 'hF00);
      chk("fb_bg_px", int'(fb[0]), 0);

      // Move right once.
      btn_right = 1'b1;
      plan_move();
      chk("model_right_draw", exp_a[64], 14298);
      do_frame(-1, fw, bf);
      chk("right_first_we_k", fw, 2);
      chk("right_busy_fall_k", bf, 130);
      chk("right_pos_x", int'(pos_x), 98);

      // Keep moving right up to the clamp.
      for (int f = 0; f < 47; f++) begin
         plan_move();
         do_frame(-1, fw, bf);
      end
      chk("clamp_pos_x", int'(pos_x), 192);
      plan_move();
      do_frame(-1, fw, bf);
      chk("clamp_no_we", fw, -1);
      chk("clamp_busy_fall_k", bf, 2);
      chk("clamp_pos_x_hold", int'(pos_x), 192);

      // Reset in the middle of a DRAW burst.
      btn_right = 1'b0;
      btn_left  = 1'b1;
      plan_move();
      @(negedge clk_px);
      vs = 1'b1;
      @(posedge clk_px);
      @(negedge clk_px);
      vs = 1'b0;
      repeat (100) @(posedge clk_px);
      #3;
      rstn = 1'b0;
      #1;
      chk("midrst_we", int'(we), 0);
      chk("midrst_busy", int'(busy), 1);
      chk("midrst_waddr", int'(waddr), 0);
      chk("midrst_pos_x", int'(pos_x), 96);
      chk("midrst_pos_y", int'(pos_y), 71);
      exp_a.delete();
      exp_d.delete();
      mx = 96;
      my = 71;
      btn_left = 1'b0;
      push_clear();
      push_box(96, 71, 'hF00);
      repeat (3) @(posedge clk_px);
      release_clear(100, 20000, bf);
      chk("reclear_busy_fall", bf, 30065);
      chk("reclear_drained", exp_a.size(), 0);
      chk("reclear_pos_x", int'(pos_x), 96);

      // Left+right cancel, up moves; a second vs during ERASE is ignored.
      btn_left  = 1'b1;
      btn_right = 1'b1;
      btn_up    = 1'b1;
      plan_move();
      chk("model_up_draw", exp_a[64], 13896);
      do_frame(20, fw, bf);
      chk("up_first_we_k", fw, 2);
      chk("up_busy_fall_k", bf, 130);
      chk("up_pos_x", int'(pos_x), 96);
      chk("up_pos_y", int'(pos_y), 69);
      btn_left  = 1'b0;
      btn_right = 1'b0;
      btn_up    = 1'b0;
      repeat (200) @(posedge clk_px);
      #1;
      chk("idle_no_extra", exp_a.size(), 0);
      chk("idle_busy", int'(busy), 0);

      cnt = 0;
      for (int i = 0; i < N; i++)
         if (fb[i] == 12'hF00) cnt++;
      chk("fb_fg_count", cnt, 64);
      chk("fb_new_top_left", int'(fb[13896]), 'hF00);
      chk("fb_new_bot_right", int'(fb[15303]), 'hF00);
      chk("fb_old_bot_row", int'(fb[15696]), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
